// File: rtl/wb_timeout_bridge.sv
// Registered single-transaction WISHBONE classic bridge that forwards one cycle downstream
// and turns a hung or unmapped access into an upstream error after TIMEOUT cycles.
module wb_timeout_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT       = 255,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [ADDRESS_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]      wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0]    wbs_sel_i,
  output logic                       wbs_ack_o,
  output logic                       wbs_err_o,
  output logic                       wbs_rty_o,
  output logic [DATA_WIDTH-1:0]      wbs_dat_o,
  output logic                       wbm_cyc_o,
  output logic                       wbm_stb_o,
  output logic                       wbm_we_o,
  output logic [ADDRESS_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]      wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0]    wbm_sel_o,
  input  logic                       wbm_ack_i,
  input  logic                       wbm_err_i,
  input  logic                       wbm_rty_i,
  input  logic [DATA_WIDTH-1:0]      wbm_dat_i,
  input  logic                       timeout_clr_i,
  output logic                       timeout_o,
  output logic [COUNT_WIDTH-1:0]     timeout_count_o
);

  localparam logic [15:0]            CYCLE_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0]            CYCLE_ONE  = 16'd1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cycle_cnt_q;
  logic        accept, abort, downstream_resp, expire, finish;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    if (&v) return v;
    return v + COUNT_ONE;
  endfunction

  // An upstream abort outranks a downstream response; a response outranks expiry.
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    abort           = 1'b0;
    downstream_resp = 1'b0;
    expire          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!wbs_cyc_i) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (wbm_ack_i || wbm_err_i || wbm_rty_i) begin
          downstream_resp = 1'b1;
          state_d         = RESP;
        end else if (cycle_cnt_q == CYCLE_LAST) begin
          expire  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    finish = abort || downstream_resp || expire;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      cycle_cnt_q <= '0;
    end else if (accept) begin
      wbm_cyc_o   <= 1'b1;
      wbm_stb_o   <= 1'b1;
      wbm_we_o    <= wbs_we_i;
      wbm_adr_o   <= wbs_adr_i;
      wbm_dat_o   <= wbs_dat_i;
      wbm_sel_o   <= wbs_sel_i;
      cycle_cnt_q <= '0;
    end else if (finish) begin
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
    end else if (state_q == ACTIVE) begin
      cycle_cnt_q <= cycle_cnt_q + CYCLE_ONE;
    end
  end

  // Upstream pulses are registered so they are visible exactly during RESP.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_rty_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= downstream_resp && !wbm_err_i && !wbm_rty_i;
      wbs_err_o <= (downstream_resp && wbm_err_i) || expire;
      wbs_rty_o <= downstream_resp && !wbm_err_i && wbm_rty_i;
      if (downstream_resp && !wbm_we_o) wbs_dat_o <= wbm_dat_i;
    end
  end

  // A timeout coinciding with a clear request still records itself as the first event.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      timeout_o       <= 1'b0;
      timeout_count_o <= '0;
    end else if (expire) begin
      timeout_o       <= 1'b1;
      timeout_count_o <= timeout_clr_i ? COUNT_ONE : sat_inc(timeout_count_o);
    end else if (timeout_clr_i) begin
      timeout_o       <= 1'b0;
      timeout_count_o <= '0;
    end
  end

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed and randomized bench for wb_timeout_bridge with a wait-state target model
// and a transaction-level expectation model.
module tb_wb_timeout_bridge;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [SW-1:0] wbs_sel_i;
  logic          wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [DW-1:0] wbs_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic          wbm_ack_i, wbm_err_i, wbm_rty_i;
  logic [DW-1:0] wbm_dat_i;
  logic          timeout_clr_i;
  logic          timeout_o;
  logic [CW-1:0] timeout_count_o;

  always #5 clk = ~clk;

  wb_timeout_bridge #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .COUNT_WIDTH(CW)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .wbs_dat_o(wbs_dat_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .wbm_dat_i(wbm_dat_i),
    .timeout_clr_i(timeout_clr_i), .timeout_o(timeout_o), .timeout_count_o(timeout_count_o)
  );

  // Target: answers after tgt_wait strobe cycles (0 = combinational) unless disabled.
  logic          tgt_en, tgt_ack, tgt_err, tgt_rty;
  int            tgt_wait;
  logic [DW-1:0] tgt_data;
  int            wcnt = 0;
  logic          respond;

  always @(posedge clk) wcnt <= (wbm_cyc_o && wbm_stb_o) ? wcnt + 1 : 0;

  assign respond   = tgt_en && wbm_cyc_o && wbm_stb_o && (wcnt == tgt_wait);
  assign wbm_ack_i = respond && tgt_ack;
  assign wbm_err_i = respond && tgt_err;
  assign wbm_rty_i = respond && tgt_rty;
  assign wbm_dat_i = tgt_data;

  int            total = 0;
  int            bad = 0;
  logic          m_flag;
  logic [CW-1:0] m_count;
  logic [DW-1:0] m_dat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input int wt, input logic never,
                         input logic a, input logic e, input logic r,
                         input logic [DW-1:0] rsp_dat, input logic hold, input logic clr_same);
    int       stbc;
    int       exp_stbc;
    logic [2:0] exp_resp;
    logic     responds;
    responds = !never && (a || e || r) && (wt < TO);
    if (responds) begin
      exp_stbc = wt + 1;
      exp_resp = e ? 3'b010 : (r ? 3'b001 : 3'b100);
      if (!we) m_dat = rsp_dat;
    end else begin
      exp_stbc = TO;
      exp_resp = 3'b010;
      m_flag   = 1'b1;
      m_count  = clr_same ? 8'd1 : ((m_count == 8'hFF) ? 8'hFF : m_count + 8'd1);
    end
    tgt_en = !never; tgt_wait = wt; tgt_ack = a; tgt_err = e; tgt_rty = r; tgt_data = rsp_dat;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    @(posedge clk); #1;
    check("req_fwd", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o},
          {1'b1, 1'b1, we, adr, sel});
    check("req_dat", wbm_dat_o, dat);
    stbc = 0;
    while (wbm_stb_o && stbc < 100) begin
      stbc++;
      if (clr_same && stbc == TO) timeout_clr_i = 1'b1;
      @(posedge clk); #1;
    end
    timeout_clr_i = 1'b0;
    check("stb_cycles", stbc, exp_stbc);
    check("resp_ack_err_rty", {wbs_ack_o, wbs_err_o, wbs_rty_o}, exp_resp);
    check("rdata", wbs_dat_o, m_dat);
    check("tstatus", {timeout_o, timeout_count_o}, {m_flag, m_count});
    if (!hold) begin
      @(negedge clk);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    end
    @(posedge clk); #1;
    if (hold) begin
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    end
    check("after_resp", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o}, 5'b0);
  endtask

  task automatic clear_status();
    @(negedge clk);
    timeout_clr_i = 1'b1;
    @(posedge clk); #1;
    timeout_clr_i = 1'b0;
    m_flag = 1'b0; m_count = '0;
    check("clear", {timeout_o, timeout_count_o}, 9'b0);
  endtask

  task automatic start_hung(input int active_cycles);
    tgt_en = 1'b0;
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 16'h0BAD; wbs_dat_i = 32'hCAFE0001; wbs_sel_i = 4'h3;
    @(posedge clk); #1;
    repeat (active_cycles - 1) begin @(posedge clk); #1; end
    check("hung_active", {wbm_cyc_o, wbm_stb_o}, 2'b11);
  endtask

  initial begin
    logic          we, nv, hd, a, e, r;
    logic [2:0]    kind;
    rst_n = 1'b0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    timeout_clr_i = 0;
    tgt_en = 0; tgt_ack = 0; tgt_err = 0; tgt_rty = 0; tgt_wait = 0; tgt_data = '0;
    m_flag = 0; m_count = '0; m_dat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                         wbm_adr_o, wbm_sel_o, timeout_o, timeout_count_o}, 35'b0);
    check("reset_dat", {wbs_dat_o, wbm_dat_o}, 64'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write with combinational ack, then read after 5 wait states.
    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0020, 32'h0, 4'hF, 5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    // Dead target: error after TO strobe cycles, then clear.
    run_txn(1'b0, 16'h0030, 32'h0, 4'hF, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55555555, 1'b0, 1'b0);
    clear_status();
    // Priority, expiry-cycle ack, retry, held strobe.
    run_txn(1'b0, 16'h0040, 32'h0, 4'h1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0050, 32'h0, 4'h2, TO - 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BB0CC0D, 1'b0, 1'b0);
    run_txn(1'b1, 16'h0060, 32'h11112222, 4'h4, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h0070, 32'h0, 4'hF, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77778888, 1'b1, 1'b0);

    // Upstream abort after 3 active cycles.
    start_hung(3);
    @(negedge clk);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check("abort_drop", {wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, wbs_rty_o}, 5'b0);
    @(posedge clk); #1;
    check("abort_quiet", {wbs_ack_o, wbs_err_o, wbs_rty_o}, 3'b0);
    check("abort_tstatus", {timeout_o, timeout_count_o}, {m_flag, m_count});

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      nv   = ($urandom_range(0, 7) == 0);
      hd   = 1'($urandom_range(0, 1));
      kind = 3'($urandom_range(0, 7));
      a = kind[0] || (kind == 3'b0); e = kind[1]; r = kind[2];
      run_txn(we, 16'($urandom), $urandom, 4'($urandom), $urandom_range(0, 10), nv, a, e, r,
              $urandom, hd, 1'b0);
    end

    // Timeout and clear in the same cycle: set wins.
    run_txn(1'b1, 16'h0080, 32'h1, 4'h1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Counter saturation.
    clear_status();
    for (int i = 0; i < 260; i++)
      run_txn(1'b1, 16'h0090, 32'h2, 4'h8, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("saturated", timeout_count_o, 8'hFF);

    // Asynchronous reset in the middle of a hung access.
    start_hung(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_flag = 1'b0; m_count = '0; m_dat = '0;
    check("async_rst_ctrl", {wbs_ack_o, wbs_err_o, wbs_rty_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                             wbm_adr_o, wbm_sel_o, timeout_o, timeout_count_o}, 35'b0);
    check("async_rst_dat", {wbs_dat_o, wbm_dat_o}, 64'b0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 16'h00A0, 32'h0, 4'hF, 3, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFEEDF00D, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
